// File: rtl/monochrome_ctrl_if.sv
// ZX-Uno register bus seen by the monochrome controller.
interface monochrome_ctrl_if;
  logic [7:0] zxuno_addr;
  logic       zxuno_regwr;
  logic       zxuno_regrd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n;

  modport master (output zxuno_addr, zxuno_regwr, zxuno_regrd, din,
                  input  dout, oe_n);
  modport slave  (input  zxuno_addr, zxuno_regwr, zxuno_regrd, din,
                  output dout, oe_n);
endinterface

// File: rtl/monochrome_ctrl.sv
// Monochrome/tint mode sequencer: CPU and hotkey requests applied at vsync.
// Optional hotkey path enabled by MONOCHROME_HOTKEY_EN.
module monochrome_ctrl #(
  parameter logic [7:0] REGADDR     = 8'h0F,
  parameter logic [5:0] KEY_HOLDOFF = 6'd16
) (
  input  logic               clk,
  input  logic               rst_n,
  monochrome_ctrl_if.slave   bus,
  input  logic               vsync,
  input  logic               key_mono,
  output logic [1:0]         monochrome_selection,
  output logic               pending
);

  typedef enum logic {ST_STABLE, ST_REQUESTED} state_t;

  state_t     r_state, w_state_nxt;
  logic       r_wr_d, r_vs_d;
  logic [1:0] r_req, r_app;
  logic       r_lock;
  logic       w_sel, w_wr, w_vs_rise, w_key_step;
  logic [7:0] w_dout;
  logic       w_oe_n;
  logic       w_unused_din;

  assign w_sel        = (bus.zxuno_addr == REGADDR);
  assign w_wr         = bus.zxuno_regwr & ~r_wr_d & w_sel;
  assign w_vs_rise    = vsync & ~r_vs_d;
  assign w_unused_din = ^bus.din[6:2];

`ifdef MONOCHROME_HOTKEY_EN
  logic       r_key_d;
  logic [5:0] r_hold;

  // A CPU write in the same cycle swallows the hotkey, holdoff untouched.
  assign w_key_step = key_mono & ~r_key_d & ~r_lock & (r_hold == 6'd0) & ~w_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_d <= 1'b0;
      r_hold  <= 6'd0;
    end else begin
      r_key_d <= key_mono;
      if (w_key_step)
        r_hold <= KEY_HOLDOFF;
      else if (w_vs_rise && r_hold != 6'd0)
        r_hold <= r_hold - 6'd1;
    end
  end
`else
  logic w_unused_key;
  assign w_unused_key = key_mono;
  assign w_key_step   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_req  <= 2'b00;
      r_app  <= 2'b00;
      r_lock <= 1'b0;
    end else begin
      r_wr_d <= bus.zxuno_regwr;
      r_vs_d <= vsync;
      // Boundary samples the pre-write req; a same-cycle write lands next frame.
      if (w_vs_rise)
        r_app <= r_req;
      if (w_wr) begin
        r_req  <= bus.din[1:0];
        r_lock <= bus.din[7];
      end else if (w_key_step) begin
        r_req <= r_req + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_STABLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_STABLE:    if (r_req != r_app) w_state_nxt = ST_REQUESTED;
      ST_REQUESTED: if (r_req == r_app) w_state_nxt = ST_STABLE;
      default:      w_state_nxt = ST_STABLE;
    endcase
  end

  always_comb begin
    w_oe_n = 1'b1;
    w_dout = 8'h00;
    if (w_sel && bus.zxuno_regrd) begin
      w_oe_n = 1'b0;
      w_dout = {r_lock, pending, 2'b00, r_app, r_req};
    end
  end

  assign pending              = (r_state == ST_REQUESTED);
  assign monochrome_selection = r_app;
  assign bus.dout             = w_dout;
  assign bus.oe_n             = w_oe_n;

endmodule

// File: tb/tb_monochrome_ctrl.sv
// Directed bench for monochrome_ctrl; register reads checked via a scoreboard.
module tb_monochrome_ctrl;
  localparam logic [7:0] ADDR = 8'h0F;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       key_mono = 1'b0;
  logic [1:0] sel;
  logic       pend;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] sb_q[$];

  monochrome_ctrl_if bus();

  monochrome_ctrl #(.REGADDR(ADDR), .KEY_HOLDOFF(6'd16)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .bus                  (bus),
    .vsync                (vsync),
    .key_mono             (key_mono),
    .monochrome_selection (sel),
    .pending              (pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic st(input string tag, input logic [1:0] exp_sel, input logic exp_pend);
    chk({tag, "_sel"}, {6'd0, sel}, {6'd0, exp_sel});
    chk({tag, "_pend"}, {7'd0, pend}, {7'd0, exp_pend});
  endtask

  task automatic rd(input string tag, input logic [7:0] mask, input logic [7:0] exp);
    sb_q.push_back(exp);
    bus.zxuno_addr  = ADDR;
    bus.zxuno_regrd = 1'b1;
    #1;
    chk({tag, "_oe"}, {7'd0, bus.oe_n}, 8'h00);
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      chk(tag, bus.dout & mask, sb_q.pop_front());
    end
    bus.zxuno_regrd = 1'b0;
    #1;
  endtask

  // Strobe held several cycles with changing data: only the first edge writes.
  task automatic wr(input logic [7:0] data, input logic [7:0] addr);
    bus.zxuno_addr  = addr;
    bus.din         = data;
    bus.zxuno_regwr = 1'b1;
    tick;
    bus.din = ~data;
    tick;
    tick;
    bus.zxuno_regwr = 1'b0;
    tick;
  endtask

  task automatic vs;
    vsync = 1'b1;
    tick;
    vsync = 1'b0;
    tick;
  endtask

  task automatic press;
    key_mono = 1'b1;
    tick;
    key_mono = 1'b0;
    tick;
  endtask

  initial begin
    bus.zxuno_addr  = 8'h00;
    bus.zxuno_regwr = 1'b0;
    bus.zxuno_regrd = 1'b0;
    bus.din         = 8'h00;

    repeat (5) tick;
    st("reset", 2'b00, 1'b0);
    chk("reset_oe", {7'd0, bus.oe_n}, 8'h01);
    chk("reset_dout", bus.dout, 8'h00);
    rst_n = 1'b1;
    tick;

    // CPU write then frame boundary
    wr(8'h02, ADDR);
    st("wr02", 2'b00, 1'b1);
    rd("rd_wr02", 8'hFF, 8'h42);
    wr(8'h03, 8'h10);
    rd("rd_badaddr_wr", 8'hFF, 8'h42);
    bus.zxuno_addr  = 8'h10;
    bus.zxuno_regrd = 1'b1;
    #1;
    chk("rd_badaddr_oe", {7'd0, bus.oe_n}, 8'h01);
    chk("rd_badaddr_dout", bus.dout, 8'h00);
    bus.zxuno_regrd = 1'b0;
    vsync = 1'b1;
    tick;
    st("vs_edge", 2'b10, 1'b1);
    vsync = 1'b0;
    tick;
    st("vs_after", 2'b10, 1'b0);
    rd("rd_applied", 8'hFF, 8'h0A);

    // Write coinciding with a boundary
    wr(8'h03, ADDR);
    vs;
    st("app11", 2'b11, 1'b0);
    bus.zxuno_addr  = ADDR;
    bus.din         = 8'h01;
    bus.zxuno_regwr = 1'b1;
    vsync           = 1'b1;
    tick;
    bus.zxuno_regwr = 1'b0;
    vsync           = 1'b0;
    st("simul_edge", 2'b11, 1'b0);
    tick;
    st("simul_after", 2'b11, 1'b1);
    rd("rd_simul", 8'hFF, 8'h4D);
    vs;
    st("simul_next_vs", 2'b01, 1'b0);
    rd("rd_simul_next", 8'hFF, 8'h05);

`ifdef MONOCHROME_HOTKEY_EN
    press;
    rd("hk_first", 8'h03, 8'h02);
    press;
    rd("hk_holdoff", 8'h03, 8'h02);
    repeat (15) vs;
    press;
    rd("hk_hold15", 8'h03, 8'h02);
    vs;
    press;
    rd("hk_hold16", 8'h03, 8'h03);
    repeat (16) vs;
    press;
    rd("hk_wrap", 8'h03, 8'h00);
    vs;
    repeat (16) vs;
`else
    press;
    press;
    rd("hk_disabled", 8'h03, 8'h01);
`endif

    // Lock bit
    wr(8'h80, ADDR);
    press;
    rd("lock", 8'h83, 8'h80);

    // Async reset with a pending request
    vs;
    wr(8'h01, ADDR);
    st("pre_rst", 2'b00, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    st("async_rst", 2'b00, 1'b0);
    rd("rd_in_rst", 8'hFF, 8'h00);
    tick;
    rst_n = 1'b1;
    tick;
    vs;
    st("post_rst_vs", 2'b00, 1'b0);
    rd("rd_post_rst", 8'hFF, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
